// File: rtl/id_ex_alu_issue_if.sv
// ID -> EX issue bus for id_ex_alu_issue: upstream handshake, decoded fields and the
// registered ALU operand/op bundle handed to EX.
interface id_ex_alu_issue_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              alu_src;
    logic [1:0]        alu_main_op;
    logic [5:0]        funct;
    logic [REG_W-1:0]  wr_reg;
    logic [4:0]        ctl_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_in0;
    logic [DATA_W-1:0] alu_in1;
    logic [3:0]        alu_op;
    logic [REG_W-1:0]  wr_reg_out;
    logic [4:0]        ctl_out;
    logic              illegal;

    // Driver side (ID stage plus EX consumer).
    modport master (
        output flush, in_valid, rs_data, rt_data, imm, alu_src, alu_main_op, funct,
               wr_reg, ctl_in, out_ready,
        input  in_ready, out_valid, alu_in0, alu_in1, alu_op, wr_reg_out, ctl_out, illegal
    );

    // The ID/EX stage itself.
    modport slave (
        input  flush, in_valid, rs_data, rt_data, imm, alu_src, alu_main_op, funct,
               wr_reg, ctl_in, out_ready,
        output in_ready, out_valid, alu_in0, alu_in1, alu_op, wr_reg_out, ctl_out, illegal
    );
endinterface

// File: rtl/id_ex_alu_issue.sv
// ID/EX register stage: decodes ALUOp/funct into a 4-bit ALU op and registers the operand pair.
// Optional feature: define ID_EX_SKID_EN for a second (skid) entry with a registered in_ready.
module id_ex_alu_issue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input logic                clk,
    input logic                rst,
    id_ex_alu_issue_if.slave   bus
);
    typedef struct packed {
        logic [DATA_W-1:0] in0;
        logic [DATA_W-1:0] in1;
        logic [3:0]        op;
        logic [REG_W-1:0]  wr;
        logic [4:0]        ctl;
        logic              ill;
    } entry_t;

    entry_t dec;
    entry_t out_q;
    logic   out_valid_q;
    logic   take;
    logic   drain;

    // Decode of the instruction currently offered by ID.
    always_comb begin
        dec     = '0;
        dec.in0 = bus.rs_data;
        dec.in1 = bus.alu_src ? bus.imm : bus.rt_data;
        dec.wr  = bus.wr_reg;
        dec.ctl = bus.ctl_in;
        dec.op  = 4'b0010;
        dec.ill = 1'b0;
        case (bus.alu_main_op)
            2'b00: dec.op = 4'b0010;
            2'b01: dec.op = 4'b0110;
            2'b11: dec.op = 4'b0001;
            default: begin
                case (bus.funct)
                    6'b100000: dec.op = 4'b0010;
                    6'b100010: dec.op = 4'b0110;
                    6'b100100: dec.op = 4'b0000;
                    6'b100101: dec.op = 4'b0001;
                    6'b101010: dec.op = 4'b0111;
                    6'b100111: dec.op = 4'b1100;
                    default: begin
                        // Unknown funct must not write back; the rest of ctl is left alone.
                        dec.op     = 4'b0010;
                        dec.ill    = 1'b1;
                        dec.ctl[4] = 1'b0;
                    end
                endcase
            end
        endcase
    end

    assign take  = bus.in_valid && bus.in_ready;
    assign drain = out_valid_q && bus.out_ready;

`ifdef ID_EX_SKID_EN
    entry_t skid_q;
    logic   skid_valid_q;

    // in_ready comes straight from the skid-occupancy flop, never from out_ready.
    assign bus.in_ready = !skid_valid_q && !rst;

    // Output entry plus one skid entry; skid always drains into the output first.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else if (bus.flush) begin
            out_valid_q  <= 1'b0;
            out_q.ctl    <= '0;
            out_q.ill    <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q) begin
            if (take) begin
                out_valid_q <= 1'b1;
                out_q       <= dec;
            end
        end else if (drain) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                skid_valid_q <= 1'b0;
            end else if (take) begin
                out_q <= dec;
            end else begin
                out_valid_q <= 1'b0;
                out_q.ctl   <= '0;
                out_q.ill   <= 1'b0;
            end
        end else if (take) begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
        end
    end
`else
    assign bus.in_ready = !rst && (!out_valid_q || bus.out_ready);

    // Single entry: load on accept, release on drain; ctl/illegal are cleared when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
            out_q.ctl   <= '0;
            out_q.ill   <= 1'b0;
        end else if (take) begin
            out_valid_q <= 1'b1;
            out_q       <= dec;
        end else if (drain) begin
            out_valid_q <= 1'b0;
            out_q.ctl   <= '0;
            out_q.ill   <= 1'b0;
        end
    end
`endif

    assign bus.out_valid  = out_valid_q;
    assign bus.alu_in0    = out_q.in0;
    assign bus.alu_in1    = out_q.in1;
    assign bus.alu_op     = out_q.op;
    assign bus.wr_reg_out = out_q.wr;
    assign bus.ctl_out    = out_q.ctl;
    assign bus.illegal    = out_q.ill;
endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed bench for id_ex_alu_issue: reset, streaming decode, operand mux, stall, flush,
// illegal funct and reset during a stall, with hand-computed expectations.
module tb_id_ex_alu_issue;
`ifdef ID_EX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    id_ex_alu_issue_if #(.DATA_W(32), .REG_W(5)) bus ();

    id_ex_alu_issue #(.DATA_W(32), .REG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [5:0] fn_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    logic [3:0] op_tab [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] mop, input logic [5:0] fn,
                         input logic src, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] im, input logic [4:0] wr, input logic [4:0] ctl);
        bus.in_valid    = v;
        bus.alu_main_op = mop;
        bus.funct       = fn;
        bus.alu_src     = src;
        bus.rs_data     = rs;
        bus.rt_data     = rt;
        bus.imm         = im;
        bus.wr_reg      = wr;
        bus.ctl_in      = ctl;
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 2'b10, 6'b100000, 1'b0, 32'h11, 32'h22, 32'h33, 5'd3, 5'b11111);

        // Reset held for three cycles with in_valid asserted.
        repeat (3) tick();
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_alu_in0", 64'(bus.alu_in0), 64'd0);
        check_eq("rst_alu_in1", 64'(bus.alu_in1), 64'd0);
        check_eq("rst_alu_op", 64'(bus.alu_op), 64'd0);
        check_eq("rst_wr_reg", 64'(bus.wr_reg_out), 64'd0);
        check_eq("rst_ctl", 64'(bus.ctl_out), 64'd0);
        check_eq("rst_illegal", 64'(bus.illegal), 64'd0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Back-to-back R-type stream with out_ready high.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 2'b10, fn_tab[i], 1'b0, 32'(i + 1), 32'(100 + i), 32'h0, 5'(i), 5'b10000);
            #1;
            check_eq($sformatf("stream_in_ready_%0d", i), 64'(bus.in_ready), 64'd1);
            tick();
            check_eq($sformatf("stream_valid_%0d", i), 64'(bus.out_valid), 64'd1);
            check_eq($sformatf("stream_op_%0d", i), 64'(bus.alu_op), 64'(op_tab[i]));
            check_eq($sformatf("stream_in0_%0d", i), 64'(bus.alu_in0), 64'(i + 1));
            check_eq($sformatf("stream_in1_%0d", i), 64'(bus.alu_in1), 64'(100 + i));
            check_eq($sformatf("stream_wr_%0d", i), 64'(bus.wr_reg_out), 64'(i));
            check_eq($sformatf("stream_ctl_%0d", i), 64'(bus.ctl_out), 64'h10);
            check_eq($sformatf("stream_ill_%0d", i), 64'(bus.illegal), 64'd0);
        end
        bus.in_valid = 1'b0;
        tick();
        check_eq("drain_valid", 64'(bus.out_valid), 64'd0);
        check_eq("drain_ctl_gated", 64'(bus.ctl_out), 64'd0);
        check_eq("drain_data_hold", 64'(bus.alu_in0), 64'd6);

        // Operand mux: immediate vs register.
        drive(1'b1, 2'b00, 6'b0, 1'b1, 32'h40, 32'h5, 32'hFFFF_FFFC, 5'd1, 5'b10000);
        tick();
        check_eq("mux_imm_in1", 64'(bus.alu_in1), 64'hFFFF_FFFC);
        check_eq("mux_imm_op", 64'(bus.alu_op), 64'h2);
        drive(1'b1, 2'b11, 6'b0, 1'b0, 32'h40, 32'h5, 32'hFFFF_FFFC, 5'd1, 5'b10000);
        tick();
        check_eq("mux_reg_in1", 64'(bus.alu_in1), 64'h5);
        check_eq("mux_or_op", 64'(bus.alu_op), 64'h1);
        bus.in_valid = 1'b0;
        tick();

        // Stall: load A accepted, then EX back-pressures for four cycles while B is offered.
        drive(1'b1, 2'b00, 6'b0, 1'b1, 32'hA0, 32'h0, 32'h4, 5'd7, 5'b11010);
        tick();
        check_eq("stall_a_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b01, 6'b0, 1'b0, 32'hB0, 32'h3, 32'h0, 5'd8, 5'b10000);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("stall_in_ready_%0d", i), 64'(bus.in_ready),
                     (i == 0) ? 64'(SKID) : 64'd0);
            tick();
            if (SKID && i == 0) bus.in_valid = 1'b0;
            check_eq($sformatf("stall_hold_in0_%0d", i), 64'(bus.alu_in0), 64'hA0);
            check_eq($sformatf("stall_hold_in1_%0d", i), 64'(bus.alu_in1), 64'h4);
            check_eq($sformatf("stall_hold_op_%0d", i), 64'(bus.alu_op), 64'h2);
            check_eq($sformatf("stall_hold_ctl_%0d", i), 64'(bus.ctl_out), 64'h1A);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_eq("stall_b_valid", 64'(bus.out_valid), 64'd1);
        check_eq("stall_b_in0", 64'(bus.alu_in0), 64'hB0);
        check_eq("stall_b_in1", 64'(bus.alu_in1), 64'h3);
        check_eq("stall_b_op", 64'(bus.alu_op), 64'h6);
        check_eq("stall_b_wr", 64'(bus.wr_reg_out), 64'd8);
        tick();
        check_eq("stall_empty", 64'(bus.out_valid), 64'd0);

        // Flush with a held entry C and a coinciding transfer-in of D.
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b00, 6'b0, 1'b0, 32'hC0, 32'h1, 32'h0, 5'd9, 5'b10000);
        tick();
        check_eq("flush_c_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        drive(1'b1, 2'b01, 6'b0, 1'b0, 32'hD0, 32'h2, 32'h0, 5'd10, 5'b10000);
        #1;
        check_eq("flush_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("flush_valid", 64'(bus.out_valid), 64'd0);
        check_eq("flush_ctl", 64'(bus.ctl_out), 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq($sformatf("flush_gone_%0d", i), 64'(bus.out_valid), 64'd0);
        end

        // Illegal funct with reg_write set.
        drive(1'b1, 2'b10, 6'b000001, 1'b0, 32'hE0, 32'h7, 32'h0, 5'd11, 5'b11111);
        tick();
        check_eq("ill_valid", 64'(bus.out_valid), 64'd1);
        check_eq("ill_flag", 64'(bus.illegal), 64'd1);
        check_eq("ill_op", 64'(bus.alu_op), 64'h2);
        check_eq("ill_ctl", 64'(bus.ctl_out), 64'h0F);
        bus.in_valid = 1'b0;
        tick();
        check_eq("ill_cleared", 64'(bus.illegal), 64'd0);

        // Reset during a stall drops the held instruction.
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b00, 6'b0, 1'b0, 32'hF0, 32'h1, 32'h0, 5'd12, 5'b10000);
        tick();
        check_eq("rst_stall_loaded", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_eq("rst_stall_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_stall_in0", 64'(bus.alu_in0), 64'd0);
        check_eq("rst_stall_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check_eq("rst_stall_no_replay", 64'(bus.out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
